// File: rtl/uart_tx_core_pkg.sv
// rtl/uart_tx_core_pkg.sv - shared enums, limits and config sanitisers for the UART transmitter
package uart_tx_core_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;

    typedef logic [3:0] data_bits_t;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_e;

    typedef enum logic [1:0] {
        STOP_BITS_1 = 2'd1,
        STOP_BITS_2 = 2'd2
    } stop_bits_e;

    typedef enum logic [4:0] {
        OVERSAMPLE_13 = 5'd13,
        OVERSAMPLE_16 = 5'd16
    } oversampling_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Clamp the data bit count into the supported 5..8 window
    function automatic data_bits_t sanitize_data_bits(input logic [3:0] v);
        if (v < 4'(DATA_BITS_MIN)) return 4'(DATA_BITS_MIN);
        if (v > 4'(DATA_BITS_MAX)) return 4'(DATA_BITS_MAX);
        return v;
    endfunction

    // 0 means one stop bit, 3 means two
    function automatic stop_bits_e sanitize_stop_bits(input logic [1:0] v);
        return (v >= 2'd2) ? STOP_BITS_2 : STOP_BITS_1;
    endfunction

    // Anything that is not 13 falls back to the classic 16x
    function automatic oversampling_e sanitize_oversampling(input logic [4:0] v);
        return (v == 5'd13) ? OVERSAMPLE_13 : OVERSAMPLE_16;
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// rtl/uart_tx_core_if.sv - valid/ready push port into the transmit FIFO
interface uart_tx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  txValid;
    logic [DATA_WIDTH-1:0] txData;
    logic                  txReady;

    modport master (output txValid, output txData, input txReady);
    modport slave  (input txValid, input txData, output txReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead FIFO shared by the UART TX and RX paths
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Overflow and underflow requests are dropped rather than corrupting state
    assign do_push = push && (count < CW'(FIFO_DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage array, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - configurable UART transmitter with buffered valid/ready input
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  cfgDataBits,
    input  logic                        cfgParityEnable,
    input  logic                        cfgParityType,
    input  logic                        cfgParityErrorInjection,
    input  logic [1:0]                  cfgStopBits,
    input  logic [4:0]                  cfgOverSampling,
    input  logic [DIV_WIDTH-1:0]        cfgBaudDivisor,
    uart_tx_core_if.slave               push_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e             state;
    tx_state_e             state_next;
    logic                  fifo_push;
    logic                  fifo_empty;
    logic                  start_frame;
    logic                  shift;
    logic                  tx_next;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    // Shadow config, frozen for the duration of one frame
    data_bits_t            data_bits_q;
    logic                  par_en_q;
    parity_e               par_type_q;
    logic                  par_inj_q;
    stop_bits_e            stop_bits_q;
    oversampling_e         os_q;
    logic [DIV_WIDTH-1:0]  div_q;

    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [4:0]            tick_cnt;
    logic [3:0]            bit_idx;
    logic [1:0]            stop_idx;
    logic                  parity_acc;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  tick;
    logic                  bit_end;

    assign push_if.txReady = fifoCount < CW'(FIFO_DEPTH);
    assign fifo_push       = push_if.txValid && push_if.txReady;
    assign fifo_empty      = (fifoCount == '0);
    assign busy            = (state != TX_IDLE);
    assign tick            = (div_cnt == div_q - DIV_WIDTH'(1));
    assign bit_end         = tick && (tick_cnt == 5'(os_q) - 5'd1);

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (start_frame),
        .wdata (push_if.txData),
        .rdata (fifo_rdata),
        .count (fifoCount)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= TX_IDLE;
        else       state <= state_next;
    end

    // Next state, pop/shift strobes and the line level for the next cycle
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift       = 1'b0;
        tx_next     = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                    state_next  = TX_START;
                end
            end
            TX_START: begin
                tx_next = 1'b0;
                if (bit_end) state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_next = shreg[0];
                if (bit_end) begin
                    shift = 1'b1;
                    if (bit_idx == data_bits_q - 4'd1)
                        state_next = par_en_q ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                tx_next = parity_acc ^ (par_type_q == PARITY_ODD) ^ par_inj_q;
                if (bit_end) state_next = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end && (stop_idx == 2'(stop_bits_q) - 2'd1)) begin
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                        state_next  = TX_START;
                    end else begin
                        state_next  = TX_IDLE;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Datapath: registered line, config latch at frame start, bit timing and shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            tx          <= 1'b1;
            data_bits_q <= 4'(DATA_BITS_MAX);
            par_en_q    <= 1'b0;
            par_type_q  <= PARITY_EVEN;
            par_inj_q   <= 1'b0;
            stop_bits_q <= STOP_BITS_1;
            os_q        <= OVERSAMPLE_16;
            div_q       <= DIV_WIDTH'(1);
            div_cnt     <= '0;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            stop_idx    <= '0;
            parity_acc  <= 1'b0;
            shreg       <= '0;
        end else begin
            tx <= tx_next;
            if (start_frame) begin
                shreg       <= fifo_rdata;
                data_bits_q <= sanitize_data_bits(cfgDataBits);
                par_en_q    <= cfgParityEnable;
                par_type_q  <= parity_e'(cfgParityType);
                par_inj_q   <= cfgParityErrorInjection;
                stop_bits_q <= sanitize_stop_bits(cfgStopBits);
                os_q        <= sanitize_oversampling(cfgOverSampling);
                div_q       <= (cfgBaudDivisor == '0) ? DIV_WIDTH'(1) : cfgBaudDivisor;
                div_cnt     <= '0;
                tick_cnt    <= '0;
                bit_idx     <= '0;
                stop_idx    <= '0;
                parity_acc  <= 1'b0;
            end else if (state != TX_IDLE) begin
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= bit_end ? 5'd0 : tick_cnt + 5'd1;
                end else begin
                    div_cnt  <= div_cnt + DIV_WIDTH'(1);
                end
                if (shift) begin
                    shreg      <= {1'b0, shreg[DATA_WIDTH-1:1]};
                    parity_acc <= parity_acc ^ shreg[0];
                    bit_idx    <= bit_idx + 4'd1;
                end
                if (state == TX_STOP && bit_end) stop_idx <= stop_idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed scoreboard bench for uart_tx_core
module tb_uart_tx_core;
    localparam int WAIT_BOUND = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cfgDataBits;
    logic        cfgParityEnable;
    logic        cfgParityType;
    logic        cfgParityErrorInjection;
    logic [1:0]  cfgStopBits;
    logic [4:0]  cfgOverSampling;
    logic [15:0] cfgBaudDivisor;
    logic        tx;
    logic        busy;
    logic [4:0]  fifoCount;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          cpb;
    } frame_t;

    frame_t sb[$];

    uart_tx_core_if #(.DATA_WIDTH(8)) push_if ();

    uart_tx_core #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .DIV_WIDTH  (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cfgDataBits             (cfgDataBits),
        .cfgParityEnable         (cfgParityEnable),
        .cfgParityType           (cfgParityType),
        .cfgParityErrorInjection (cfgParityErrorInjection),
        .cfgStopBits             (cfgStopBits),
        .cfgOverSampling         (cfgOverSampling),
        .cfgBaudDivisor          (cfgBaudDivisor),
        .push_if                 (push_if),
        .tx                      (tx),
        .busy                    (busy),
        .fifoCount               (fifoCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic frame_t make_frame(input logic [7:0] d, input int db, input int pe,
                                          input int pt, input int pi, input int sbits, input int cpb);
        frame_t f;
        int     n;
        logic   par;
        f.bits = '0;
        n      = 1;
        par    = 1'b0;
        for (int i = 0; i < db; i++) begin
            f.bits[n] = d[i];
            par       = par ^ d[i];
            n++;
        end
        if (pe != 0) begin
            f.bits[n] = par ^ (pt != 0) ^ (pi != 0);
            n++;
        end
        for (int i = 0; i < sbits; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        f.cpb   = cpb;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push_byte(input logic [7:0] d, input int db, input int pe, input int pt,
                             input int pi, input int sbits, input int cpb, output int acc_cyc);
        push_if.txValid = 1'b1;
        push_if.txData  = d;
        sb.push_back(make_frame(d, db, pe, pt, pi, sbits, cpb));
        @(negedge clk);
        push_if.txValid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic recv_frame(input string tag, output int fall_cyc);
        frame_t      f;
        logic [15:0] got;
        logic        busy_ok;
        int          waited;
        fall_cyc = 0;
        chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        f      = sb.pop_front();
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < WAIT_BOUND);
        chk({tag, "_start"}, 32'(tx), 32'd0);
        fall_cyc = cyc;
        got      = '0;
        busy_ok  = 1'b1;
        repeat (f.cpb / 2) @(negedge clk);
        for (int i = 0; i < f.nbits; i++) begin
            if (i > 0) repeat (f.cpb) @(negedge clk);
            got[i] = tx;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_bits"}, 32'(got), 32'(f.bits));
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int waited = 0;
        while (busy !== 1'b0 && waited < WAIT_BOUND) begin
            @(negedge clk);
            waited++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int   a0, a1, f0, f1, n_acc, prev_fc, fc;
        logic saw_low;

        reset                   = 1'b1;
        cfgDataBits             = 4'd8;
        cfgParityEnable         = 1'b1;
        cfgParityType           = 1'b0;
        cfgParityErrorInjection = 1'b0;
        cfgStopBits             = 2'd1;
        cfgOverSampling         = 5'd16;
        cfgBaudDivisor          = 16'd1;
        push_if.txValid         = 1'b0;
        push_if.txData          = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifoCount), 32'd0);
        chk("rst_ready", 32'(push_if.txReady), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 8E1, 16 cycles per bit, two identical frames back to back
        push_byte(8'hA5, 8, 1, 0, 0, 1, 16, a0);
        push_byte(8'hA5, 8, 1, 0, 0, 1, 16, a1);
        recv_frame("8e1_a", f0);
        chk("latency", 32'(f0 - a0), 32'd2);
        recv_frame("8e1_b", f1);
        chk("8e1_len", 32'(f1 - f0), 32'd176);

        // 5O2, 26 cycles per bit
        cfgDataBits     = 4'd5;
        cfgParityType   = 1'b1;
        cfgStopBits     = 2'd2;
        cfgOverSampling = 5'd13;
        cfgBaudDivisor  = 16'd2;
        push_byte(8'hFF, 5, 1, 1, 0, 2, 26, a0);
        push_byte(8'hFF, 5, 1, 1, 0, 2, 26, a1);
        recv_frame("5o2_a", f0);
        recv_frame("5o2_b", f1);
        chk("5o2_len", 32'(f1 - f0), 32'd234);

        // 8E1 with parity error injection
        wait_idle("idle_inj");
        cfgDataBits             = 4'd8;
        cfgParityType           = 1'b0;
        cfgParityErrorInjection = 1'b1;
        cfgStopBits             = 2'd1;
        cfgOverSampling         = 5'd16;
        cfgBaudDivisor          = 16'd1;
        push_byte(8'hA5, 8, 1, 0, 1, 1, 16, a0);
        recv_frame("inj", f0);

        // Backpressure: fill with incrementing bytes, then drain back to back
        wait_idle("idle_bp");
        cfgParityEnable         = 1'b0;
        cfgParityErrorInjection = 1'b0;
        cfgBaudDivisor          = 16'd100;
        n_acc                   = 0;
        fork
            begin
                repeat (40) begin
                    if (push_if.txReady === 1'b1) begin
                        push_if.txData = 8'(n_acc);
                        sb.push_back(make_frame(8'(n_acc), 8, 0, 0, 0, 1, (n_acc == 0) ? 1600 : 64));
                        n_acc++;
                    end
                    push_if.txValid = 1'b1;
                    @(negedge clk);
                end
                push_if.txValid = 1'b0;
                chk("bp_accepted", 32'(n_acc), 32'd17);
                chk("bp_count", 32'(fifoCount), 32'd16);
                chk("bp_ready", 32'(push_if.txReady), 32'd0);
                cfgBaudDivisor = 16'd4;
            end
            begin
                prev_fc = 0;
                for (int k = 0; k < 17; k++) begin
                    recv_frame($sformatf("bp%0d", k), fc);
                    if (k > 0) chk($sformatf("bp_gap%0d", k), 32'(fc - prev_fc), 32'((k == 1) ? 16000 : 640));
                    prev_fc = fc;
                end
            end
        join

        // Mid-frame data-bit change only affects the following frame
        wait_idle("idle_mid");
        cfgBaudDivisor = 16'd1;
        push_byte(8'h3C, 8, 0, 0, 0, 1, 16, a0);
        push_byte(8'hC3, 5, 0, 0, 0, 1, 16, a1);
        fork
            begin
                recv_frame("mid_a", f0);
                recv_frame("mid_b", f1);
            end
            begin
                repeat (40) @(negedge clk);
                cfgDataBits = 4'd5;
            end
        join
        chk("mid_len", 32'(f1 - f0), 32'd160);

        // Reset in the middle of a frame flushes everything
        wait_idle("idle_rst");
        push_byte(8'h55, 5, 0, 0, 0, 1, 16, a0);
        push_byte(8'h66, 5, 0, 0, 0, 1, 16, a1);
        repeat (30) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_count", 32'(fifoCount), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(fifoCount), 32'd0);
        reset = 1'b0;
        sb.delete();
        saw_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        chk("post_rst_quiet", 32'(saw_low), 32'd0);

        // Out-of-range config is sanitised to 5 data bits, 1 stop, 16 cycles per bit
        cfgDataBits     = 4'd3;
        cfgStopBits     = 2'd0;
        cfgOverSampling = 5'd10;
        cfgBaudDivisor  = 16'd0;
        push_byte(8'h1B, 5, 0, 0, 0, 1, 16, a0);
        push_byte(8'h1B, 5, 0, 0, 0, 1, 16, a1);
        recv_frame("oor_a", f0);
        recv_frame("oor_b", f1);
        chk("oor_len", 32'(f1 - f0), 32'd112);

        wait_idle("idle_end");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Runtime-configurable UART transmitter for the DUT side of the UART environment. It generalises the fixed 8-bit frame to 5–8 data bits, optional even/odd parity with error injection, 1 or 2 stop bits, and 13x/16x oversampled bit timing from a programmable divisor. A parametrised FIFO with a valid/ready push port buffers bytes, and the block streams frames back-to-back on a single serial line.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame and width of the push data port
FIFO_DEPTH, 16, number of buffered bytes; must be a power of two, at least 2
DIV_WIDTH, 16, width of the baud divisor

Ports:
clk  in  1  single system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
cfgDataBits  in  4  data bits per frame, 5..8
cfgParityEnable  in  1  1 = append parity bit
cfgParityType  in  1  0 = even, 1 = odd
cfgParityErrorInjection  in  1  1 = invert the transmitted parity bit
cfgStopBits  in  2  1 or 2 stop bits
cfgOverSampling  in  5  13 or 16 ticks per bit
cfgBaudDivisor  in  DIV_WIDTH  clk cycles per oversampling tick
txValid  in  1  push request
txData  in  DATA_WIDTH  byte to send, LSB first
txReady  out  1  FIFO can accept a byte
tx  out  1  serial line, idle high
busy  out  1  frame in progress
fifoCount  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: tx=1, busy=0, fifoCount=0, txReady=1. The FSM is in IDLE. All counters are cleared. The FIFO is flushed.
- Reset mid-frame: the frame is aborted, tx=1 from the next edge, and buffered data is discarded.
- Push: occurs on any edge where txValid && txReady. txReady = (fifoCount < FIFO_DEPTH), a registered-count compare, so txReady is low when full.
- Pop and push on the same edge are both honoured. fifoCount is unchanged in that case.
- Config is sampled into shadow registers when a frame starts (IDLE -> START or STOP -> START). Changes mid-frame take effect on the next frame.
- Config sanitising is applied at latch time:
  - cfgDataBits <5 -> 5, >8 -> 8.
  - cfgStopBits 0 -> 1, 3 -> 2.
  - cfgOverSampling other than 13 -> 16.
  - cfgBaudDivisor 0 -> 1.
- Bit time = divisor × oversampling clk cycles. A divisor counter generates ticks and a tick counter counts to the oversampling value per bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO not empty, pop into the shift register, latch config, go to START. Otherwise stay, with tx=1.
  - START: tx=0 for one bit time.
  - DATA: shift the LSB out each bit time. After cfgDataBits bits go to PARITY if enabled, otherwise STOP. Bits above cfgDataBits are ignored.
  - PARITY: tx = XOR of the sent data bits, XOR cfgParityType, XOR cfgParityErrorInjection.
  - STOP: tx=1 for cfgStopBits bit times. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: with the core idle and the FIFO empty, a byte accepted at edge N appears in the FIFO after N. It is popped at N+1, and tx falls at N+2 (tx is registered).
- busy = 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Frame length in bit times = 1 + dataBits + parityEnable + stopBits.

Decomposition:
- Add to UartGlobalPkg:
  - tx FSM state enum.
  - DATA_BITS_MIN=5 and DATA_BITS_MAX=8 constants.
  - Reuse the existing parity, oversampling, stop-bit and data-type enums for the cfg field encodings.
- Sub-module uart_tx_fifo: synchronous FIFO with parameters DATA_WIDTH and FIFO_DEPTH and ports push, pop, wdata, rdata, count. It is shared later with the RX path.

Test Plan:
- Frame 8E1 at 16 cycles/bit: divisor=1, oversampling 16, 8 bits, even parity, 1 stop, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 16 cycles (176 cycles total), busy high throughout.
- Frame 5O2 at 26 cycles/bit: divisor=2, oversampling 13, 5 bits, odd parity, 2 stop, push 0xFF -> tx 0,1,1,1,1,1,0,1,1, each bit 26 cycles. Upper 3 bits are not sent.
- Parity error injection: 8E1 with injection=1, push 0xA5 -> parity bit transmitted as 1, all other bits as in the 8E1 case.
- FIFO backpressure: divisor=100, txValid held high with incrementing data from 0x00 -> 17 bytes accepted (1 in the shifter, 16 buffered), then txReady=0 with fifoCount=16. After the first frame ends, bytes go out in order 0x00..0x10 with no idle gap between frames.
- Mid-frame config change and reset: change cfgDataBits 8->5 during the DATA state -> current frame still sends 8 bits and the next frame sends 5. Assert reset mid-frame -> tx=1, busy=0, fifoCount=0 on the following edge, and no further frames.
- Out-of-range config: cfgDataBits=3, cfgStopBits=0, cfgOverSampling=10, divisor=0 -> frame sent as 5 data bits, 1 stop bit, 16 cycles/bit.
